// File: rtl/dmem_pkg.sv
// ============================================================================
// Package  : dmem_pkg
// Brief    : Shared funct3 codes, FSM encoding and size helper for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Number of bytes touched by an access; the low funct3 bits encode the size.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_check.sv
// ============================================================================
// Module   : dmem_access_check
// Brief    : Combinational legality check of a load/store (funct3, alignment, range).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_check #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    output logic              illegal
);
    import dmem_pkg::*;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    logic            funct3_bad;
    logic            misaligned;
    logic            out_of_range;
    logic [ADDR_W:0] end_addr;

    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W: funct3_bad = 1'b0;
            F3_BU, F3_HU:     funct3_bad = we;
            default:          funct3_bad = 1'b1;
        endcase

        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b0;
        endcase

        // One extra bit keeps addresses near the top of the space from wrapping past the limit.
        end_addr     = {1'b0, addr} + (ADDR_W+1)'(access_bytes(funct3));
        out_of_range = end_addr > LIMIT;

        illegal = funct3_bad | misaligned | out_of_range;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter in front of single-port data_memory, IDLE/ACCESS/RESP FSM.
//            DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie (default: round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [2:0]        r0_funct3,
    output logic              r0_rsp_valid,
    output logic [31:0]       r0_rsp_rdata,
    output logic              r0_rsp_err,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [2:0]        r1_funct3,
    output logic              r1_rsp_valid,
    output logic [31:0]       r1_rsp_rdata,
    output logic              r1_rsp_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata
);
    import dmem_pkg::*;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              rr_last;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;
    logic              lat_port;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              any_valid;
    logic              tie_pick;
    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [2:0]        win_funct3;
    logic              win_illegal;
    logic              accept;

    assign any_valid = r0_req_valid | r1_req_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // rr_last keeps updating but has no say in the tie.
    assign tie_pick = 1'b0 & rr_last;
`else
    assign tie_pick = ~rr_last;
`endif

    assign win_port   = (r0_req_valid & r1_req_valid) ? tie_pick : r1_req_valid;
    assign win_we     = win_port ? r1_we     : r0_we;
    assign win_addr   = win_port ? r1_addr   : r0_addr;
    assign win_wdata  = win_port ? r1_wdata  : r0_wdata;
    assign win_funct3 = win_port ? r1_funct3 : r0_funct3;
    assign accept     = (state == IDLE) & any_valid;

    dmem_access_check #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .we      (win_we),
        .addr    (win_addr),
        .funct3  (win_funct3),
        .illegal (win_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    next_state = win_illegal ? RESP : ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Reset masks every output so an in-flight store never reaches memory.
    always_comb begin
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r0_rsp_rdata = 32'd0;
        r0_rsp_err   = 1'b0;
        r1_rsp_valid = 1'b0;
        r1_rsp_rdata = 32'd0;
        r1_rsp_err   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 32'd0;
        mem_funct3   = 3'd0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        r0_req_ready = ~win_port;
                        r1_req_ready = win_port;
                    end
                end
                ACCESS: begin
                    mem_read   = ~lat_we;
                    mem_write  = lat_we;
                    mem_addr   = lat_addr;
                    mem_wdata  = lat_wdata;
                    mem_funct3 = lat_funct3;
                end
                RESP: begin
                    if (lat_port) begin
                        r1_rsp_valid = 1'b1;
                        r1_rsp_rdata = rsp_rdata_q;
                        r1_rsp_err   = rsp_err_q;
                    end else begin
                        r0_rsp_valid = 1'b1;
                        r0_rsp_rdata = rsp_rdata_q;
                        r0_rsp_err   = rsp_err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last     <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= 32'd0;
            lat_funct3  <= 3'd0;
            lat_port    <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rr_last     <= win_port;
            lat_we      <= win_we;
            lat_addr    <= win_addr;
            lat_wdata   <= win_wdata;
            lat_funct3  <= win_funct3;
            lat_port    <= win_port;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= win_illegal;
        end else if ((state == ACCESS) && !lat_we) begin
            rsp_rdata_q <= mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed + randomized bench for dmem_arbiter with a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        r0_req_valid = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
    logic [2:0]  r0_funct3 = 3'd0;
    logic        r0_req_ready, r0_rsp_valid, r0_rsp_err;
    logic [31:0] r0_rsp_rdata;

    logic        r1_req_valid = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic [2:0]  r1_funct3 = 3'd0;
    logic        r1_req_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r1_rsp_rdata;

    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_we(r0_we),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_funct3(r0_funct3),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_we(r1_we),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_funct3(r1_funct3),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    function automatic logic [31:0] ld_ext(input logic [2:0] f, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'd0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Stand-in for data_memory: combinational extended read, byte-lane write on the edge.
    logic [7:0] dmem [MEM_BYTES];
    logic       stub_inited = 1'b0;
    int         rd_i, wr_i;

    always_comb begin
        rd_i      = int'(mem_addr[9:0]);
        mem_rdata = ld_ext(mem_funct3, dmem[rd_i], dmem[(rd_i + 1) % MEM_BYTES],
                           dmem[(rd_i + 2) % MEM_BYTES], dmem[(rd_i + 3) % MEM_BYTES]);
    end

    always @(posedge clk) begin
        if (!stub_inited) begin
            for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= init_byte(i);
            stub_inited <= 1'b1;
        end else if (mem_write) begin
            wr_i = int'(mem_addr[9:0]);
            dmem[wr_i] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) dmem[(wr_i + 1) % MEM_BYTES] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                dmem[(wr_i + 2) % MEM_BYTES] <= mem_wdata[23:16];
                dmem[(wr_i + 3) % MEM_BYTES] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [MEM_BYTES];
    bit         ref_inited = 1'b0;

    function automatic bit illegal_ref(input logic we, input logic [31:0] a, input logic [2:0] f);
        longint size;
        case (f)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        return 1'b1;
        endcase
        if (we && f[2]) return 1'b1;
        if ((longint'({32'd0, a}) % size) != 0) return 1'b1;
        return (longint'({32'd0, a}) + size) > MEM_BYTES;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
        int n;
        n = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        int i;
        i = int'(a[9:0]);
        return ld_ext(f, ref_mem[i], ref_mem[(i + 1) % MEM_BYTES],
                      ref_mem[(i + 2) % MEM_BYTES], ref_mem[(i + 3) % MEM_BYTES]);
    endfunction

    logic        pend_valid = 1'b0;
    int          pend_cyc;
    logic        pend_port, pend_we, pend_err;
    logic [31:0] pend_addr, pend_wdata;
    logic [2:0]  pend_f3;
    int          last_grant = 1;

    logic [1:0]  acc_seen = 2'b00;
    int          rsp_cnt [2] = '{0, 0};
    int          rsp_cyc [2] = '{0, 0};
    int          acc_cyc [2] = '{0, 0};
    logic [31:0] rsp_rdata_seen [2];
    logic        rsp_err_seen [2];
    int          mw_cnt = 0;
    int          strobe_cnt = 0;
    int          act_grants [$];

    always @(negedge clk) begin : monitor
        logic [127:0] exp_mem, exp_rsp;
        logic [1:0]   exp_rdy;
        logic [31:0]  rd;
        bit           idle;
        int           win;
        if (!ref_inited) begin
            for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
            ref_inited = 1'b1;
        end
        if (rst) begin
            check_eq("rst_ready", {r1_req_ready, r0_req_ready}, 0);
            check_eq("rst_mem", {mem_read, mem_write, mem_addr, mem_wdata, mem_funct3}, 0);
            check_eq("rst_rsp", {r1_rsp_valid, r1_rsp_err, r1_rsp_rdata,
                                 r0_rsp_valid, r0_rsp_err, r0_rsp_rdata}, 0);
            pend_valid = 1'b0;
            last_grant = 1;
            acc_seen   = 2'b00;
        end else begin
            exp_mem = '0;
            exp_rsp = '0;
            exp_rdy = 2'b00;
            idle    = !pend_valid;
            if (pend_valid && !pend_err && cyc == pend_cyc + 1)
                exp_mem = {59'd0, ~pend_we, pend_we, pend_addr, pend_wdata, pend_f3};
            if (pend_valid && cyc == pend_cyc + (pend_err ? 1 : 2)) begin
                rd = 32'd0;
                if (!pend_err) begin
                    if (pend_we) ref_store(pend_addr, pend_wdata, pend_f3);
                    else         rd = ref_load(pend_addr, pend_f3);
                end
                if (pend_port) exp_rsp[67:34] = {1'b1, pend_err, rd};
                else           exp_rsp[33:0]  = {1'b1, pend_err, rd};
                pend_valid = 1'b0;
            end
            check_eq("mem_bus", {mem_read, mem_write, mem_addr, mem_wdata, mem_funct3}, exp_mem);
            check_eq("rsp_bus", {r1_rsp_valid, r1_rsp_err, r1_rsp_rdata,
                                 r0_rsp_valid, r0_rsp_err, r0_rsp_rdata}, exp_rsp);

            if (idle && (r0_req_valid || r1_req_valid)) begin
                if (r0_req_valid && r1_req_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    win = 0;
`else
                    win = 1 - last_grant;
`endif
                end else begin
                    win = r1_req_valid ? 1 : 0;
                end
                exp_rdy[win] = 1'b1;
                last_grant   = win;
                pend_valid   = 1'b1;
                pend_cyc     = cyc;
                pend_port    = (win == 1);
                pend_we      = win ? r1_we     : r0_we;
                pend_addr    = win ? r1_addr   : r0_addr;
                pend_wdata   = win ? r1_wdata  : r0_wdata;
                pend_f3      = win ? r1_funct3 : r0_funct3;
                pend_err     = illegal_ref(pend_we, pend_addr, pend_f3);
            end
            check_eq("ready", {r1_req_ready, r0_req_ready}, exp_rdy);

            acc_seen = {r1_req_ready & r1_req_valid, r0_req_ready & r0_req_valid};
            if (acc_seen[0]) begin act_grants.push_back(0); acc_cyc[0] = cyc; end
            if (acc_seen[1]) begin act_grants.push_back(1); acc_cyc[1] = cyc; end
            if (r0_rsp_valid) begin
                rsp_cnt[0]++; rsp_cyc[0] = cyc;
                rsp_rdata_seen[0] = r0_rsp_rdata; rsp_err_seen[0] = r0_rsp_err;
            end
            if (r1_rsp_valid) begin
                rsp_cnt[1]++; rsp_cyc[1] = cyc;
                rsp_rdata_seen[1] = r1_rsp_rdata; rsp_err_seen[1] = r1_rsp_err;
            end
            mw_cnt     += int'(mem_write);
            strobe_cnt += int'(mem_write | mem_read);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f);
        if (p == 0) begin
            r0_req_valid = v; r0_we = we; r0_addr = a; r0_wdata = wd; r0_funct3 = f;
        end else begin
            r1_req_valid = v; r1_we = we; r1_addr = a; r1_wdata = wd; r1_funct3 = f;
        end
    endtask

    task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f, output logic err, output logic [31:0] rd,
                          output int lat);
        int n0;
        bit ok;
        n0 = rsp_cnt[p];
        drive(p, 1'b1, we, a, wd, f);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #2;
            ok = acc_seen[p];
        end
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        check_eq("accept", ok, 1);
        for (int i = 0; i < 10 && rsp_cnt[p] == n0; i++) begin
            @(posedge clk); #2;
        end
        check_eq("rsp_seen", rsp_cnt[p] - n0, 1);
        err = rsp_err_seen[p];
        rd  = rsp_rdata_seen[p];
        lat = rsp_cyc[p] - acc_cyc[p];
    endtask

    task automatic err_case(input string tag, input logic we, input logic [31:0] a, input logic [2:0] f);
        logic        e;
        logic [31:0] d;
        int          l, s0;
        s0 = strobe_cnt;
        do_req(0, we, a, 32'hDEADBEEF, f, e, d, l);
        check_eq(tag, {e, d}, {1'b1, 32'd0});
        check_eq({tag, "_nostrobe"}, strobe_cnt - s0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            1:       return 32'd1016 + 32'($urandom_range(0, 11));
            default: return 32'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic rand_port(input int p, input int ncyc);
        bit v;
        v = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #2;
            if (!v || acc_seen[p]) begin
                if ($urandom_range(0, 2) != 0) begin
                    v = 1'b1;
                    drive(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                          3'($urandom_range(0, 7)));
                end else begin
                    v = 1'b0;
                    drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
                end
            end
        end
        @(posedge clk); #2;
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d;
        int          l, m0, n0, g0;
        bit          ok;
        int          exp_tie [4];

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        m0 = mw_cnt;
        do_req(0, 1'b1, 32'h4, 32'h12345678, F3_B, e, d, l);
        check_eq("sb_rsp", {e, d}, {1'b0, 32'd0});
        check_eq("sb_latency", l, 2);
        check_eq("sb_write_cycles", mw_cnt - m0, 1);
        do_req(0, 1'b0, 32'h4, 32'd0, F3_B, e, d, l);
        check_eq("lb_rsp", {e, d}, {1'b0, 32'h00000078});

        do_req(0, 1'b1, 32'h8, 32'hAABBCCDD, F3_H, e, d, l);
        check_eq("sh_rsp", {e, d}, {1'b0, 32'd0});
        do_req(0, 1'b0, 32'h8, 32'd0, F3_H, e, d, l);
        check_eq("lh_rsp", {e, d}, {1'b0, 32'hFFFFCCDD});
        do_req(1, 1'b0, 32'h8, 32'd0, F3_HU, e, d, l);
        check_eq("lhu_rsp", {e, d}, {1'b0, 32'h0000CCDD});

        do_req(0, 1'b0, 32'h3FF, 32'd0, F3_B, e, d, l);
        check_eq("lb_top_ok", e, 0);
        do_req(0, 1'b0, 32'h3FE, 32'd0, F3_H, e, d, l);
        check_eq("lh_top_ok", e, 0);
        do_req(1, 1'b0, 32'h3FC, 32'd0, F3_W, e, d, l);
        check_eq("lw_top_ok", e, 0);

        err_case("err_lw_misalign", 1'b0, 32'h6, F3_W);
        err_case("err_sh_misalign", 1'b1, 32'h3, F3_H);
        err_case("err_store_f3_100", 1'b1, 32'h0, 3'b100);
        err_case("err_lw_3fe", 1'b0, 32'h3FE, F3_W);
        err_case("err_lw_wrap", 1'b0, 32'hFFFFFFFC, F3_W);
        err_case("err_lb_400", 1'b0, 32'h400, F3_B);
        err_case("err_load_f3_011", 1'b0, 32'h0, 3'b011);

        // A store aborted by reset during its memory cycle must leave memory untouched.
        do_req(0, 1'b1, 32'h10, 32'hCAFEF00D, F3_W, e, d, l);
        n0 = rsp_cnt[0];
        m0 = mw_cnt;
        drive(0, 1'b1, 1'b1, 32'h10, 32'h11223344, F3_W);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #2;
            ok = acc_seen[0];
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("abort_accept", ok, 1);
        check_eq("abort_no_rsp", rsp_cnt[0] - n0, 0);
        check_eq("abort_no_write", mw_cnt - m0, 0);
        do_req(0, 1'b0, 32'h10, 32'd0, F3_W, e, d, l);
        check_eq("lw_after_abort", {e, d}, {1'b0, 32'hCAFEF00D});

        // Tie behaviour from a fresh reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        g0 = act_grants.size();
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0, F3_W);
        drive(1, 1'b1, 1'b0, 32'h24, 32'd0, F3_W);
        for (int i = 0; i < 60 && act_grants.size() < g0 + 4; i++) begin
            @(posedge clk); #2;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_tie = '{0, 0, 0, 0};
`else
        exp_tie = '{0, 1, 0, 1};
`endif
        check_eq("tie_grant_count", act_grants.size() >= g0 + 4, 1);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("tie_grant%0d", k),
                     (g0 + k < act_grants.size()) ? act_grants[g0 + k] : 9, exp_tie[k]);
        repeat (4) @(posedge clk);

        fork
            rand_port(0, 300);
            rand_port(1, 300);
        join
        repeat (6) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
